// File: rtl/serial_port.sv
// serial_port: 8N1 UART behind the CPU serial window (data 0xBF00, state 0xBF01).
// Define SERIAL_LOOPBACK_EN to feed the receiver from txd instead of the rxd pin.
module serial_port #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] index,
  input  logic       rd_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] serialPortData,
  output logic [1:0] serialPortState
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
  } rx_state_t;

  logic          sel;
  logic          rd_ack;
  logic          tx_accept;
  logic          tx_bit_end;
  logic          tx_ready;
  tx_state_t     tx_state;
  tx_state_t     tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_buf;

  logic          rx_in;
  logic [1:0]    rx_sync;
  logic          rx_s;
  rx_state_t     rx_state;
  rx_state_t     rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shreg;
  logic          rx_bit_end;
  logic          rx_half_end;
  logic          rx_cnt_clr;
  logic          rx_shift;
  logic          rx_done;
  logic [7:0]    rx_hold;
  logic          rx_avail;

  assign sel        = index == 2'b10;
  assign rd_ack     = rd_en && sel;
  assign tx_bit_end = tx_cnt == BIT_END;
  assign tx_ready   = tx_state == TX_IDLE;

  // Accepting in the last STOP cycle gives back-to-back frames
  assign tx_accept = wr_en && sel &&
                     (tx_ready || (tx_state == TX_STOP && tx_bit_end));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (tx_accept) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_next = tx_accept ? TX_START : TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    unique case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_buf[tx_idx];
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_buf <= '0;
    end else begin
      if (tx_accept) tx_buf <= wr_data;
      if (tx_ready || tx_bit_end) tx_cnt <= '0;
      else                        tx_cnt <= tx_cnt + 1'b1;
      if (tx_state != TX_DATA) tx_idx <= '0;
      else if (tx_bit_end)     tx_idx <= tx_idx + 1'b1;
    end
  end

`ifdef SERIAL_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_in      = txd;
`else
  assign rx_in = rxd;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], rx_in};
  end

  assign rx_s        = rx_sync[1];
  assign rx_bit_end  = rx_cnt == BIT_END;
  assign rx_half_end = rx_cnt == HALF_END;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (rx_half_end) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_bit_end) rx_next = rx_s ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_s) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Counter restarts at mid-start so later samples land mid-bit
  always_comb begin
    rx_cnt_clr = rx_bit_end;
    rx_shift   = 1'b0;
    rx_done    = 1'b0;
    unique case (rx_state)
      RX_IDLE:  rx_cnt_clr = 1'b1;
      RX_BREAK: rx_cnt_clr = 1'b1;
      RX_START: rx_cnt_clr = rx_half_end;
      RX_DATA:  rx_shift   = rx_bit_end;
      RX_STOP:  rx_done    = rx_bit_end && rx_s;
      default:  rx_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
    end else begin
      if (rx_cnt_clr) rx_cnt <= '0;
      else            rx_cnt <= rx_cnt + 1'b1;
      if (rx_state != RX_DATA) rx_idx <= '0;
      else if (rx_bit_end)     rx_idx <= rx_idx + 1'b1;
      if (rx_shift) rx_shreg <= {rx_s, rx_shreg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_hold  <= '0;
      rx_avail <= 1'b0;
    end else begin
      if (rx_done) rx_hold <= rx_shreg;
      if (rx_done)     rx_avail <= 1'b1;
      else if (rd_ack) rx_avail <= 1'b0;
    end
  end

  assign serialPortData  = rx_hold;
  assign serialPortState = {rx_avail, tx_ready};

endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: random stimulus against a queue scoreboard for serial_port.
// TX frames and RX deliveries are checked by two independent monitors.
module tb_serial_port;

  localparam int CPB = 8;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic [1:0] index   = 2'b00;
  logic       rd_en   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rxd     = 1'b1;
  logic       txd;
  logic [7:0] serialPortData;
  logic [1:0] serialPortState;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_until = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] exp_data  = 8'h00;
  logic       exp_avail = 1'b0;

  serial_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .index(index),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rxd(rxd),
    .txd(txd),
    .serialPortData(serialPortData),
    .serialPortState(serialPortState)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_status(input string tag);
    logic [1:0] es;
    es = {exp_avail, cyc >= busy_until};
    check({tag, "_state"}, {6'b0, serialPortState}, {6'b0, es});
    check({tag, "_data"}, serialPortData, exp_data);
  endtask

  // Model: a write sampled at edge c is taken iff TX is free by edge c
  task automatic do_write(input logic [1:0] idx, input logic [7:0] d);
    int c;
    @(posedge clk); #1;
    index = idx; wr_en = 1'b1; wr_data = d;
    c = cyc + 1;
    if (idx == 2'b10 && c >= busy_until) begin
      tx_exp.push_back(d);
      busy_until = c + 10 * CPB;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; index = 2'b00;
  endtask

  task automatic do_read(input logic [1:0] idx);
    @(posedge clk); #1;
    index = idx; rd_en = 1'b1;
    if (idx == 2'b10) exp_avail = 1'b0;
    @(posedge clk); #1;
    rd_en = 1'b0; index = 2'b00;
  endtask

  task automatic wait_tx_idle();
    while (cyc < busy_until + 2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    if (stop_ok) begin
      rx_exp.push_back(b);
      exp_data = b;
      exp_avail = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      rxd = f[k];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // TX monitor: one 10-bit frame per falling txd, checked every cycle
  int         tm_cnt = 0;
  logic       tm_act = 1'b0;
  logic       tm_bad = 1'b0;
  logic       tm_orphan = 1'b0;
  logic [7:0] tm_exp = 8'h00;
  logic [7:0] tm_got = 8'h00;
  logic [9:0] tm_frame = 10'h3ff;

  always @(negedge clk) begin
    if (!rst) tm_act = 1'b0;
    else begin
      if (tm_act && tm_cnt == 10 * CPB) begin
        tm_act = 1'b0;
        if (!tm_orphan) begin
          n_vec++;
          if (tm_bad) begin
            n_err++;
            $display("FAIL tx_frame: got %h, want %h with exact bit timing",
                     tm_got, tm_exp);
          end
        end
        if (txd) begin
          n_vec++;
          if (serialPortState[0] !== 1'b1) begin
            n_err++;
            $display("FAIL tx_ready_end: got %b, want 1", serialPortState[0]);
          end
        end
      end
      if (!tm_act && !txd) begin
        tm_act = 1'b1; tm_cnt = 0; tm_bad = 1'b0;
        tm_got = 8'h00; tm_orphan = 1'b0;
        if (tx_exp.size() == 0) begin
          tm_orphan = 1'b1;
          n_vec++; n_err++;
          $display("FAIL tx_unexpected: got frame start, want idle line");
        end else tm_exp = tx_exp.pop_front();
        tm_frame = {1'b1, tm_exp, 1'b0};
      end
      if (tm_act) begin
        if (txd !== tm_frame[tm_cnt / CPB] || serialPortState[0] !== 1'b0)
          tm_bad = 1'b1;
        if (tm_cnt % CPB == CPB / 2 && tm_cnt / CPB inside {[1:8]})
          tm_got[tm_cnt / CPB - 1] = txd;
        tm_cnt++;
      end
    end
  end

  // RX monitor: a delivery is a rise of RX-available or a new data value
  logic [7:0] pm_data  = 8'h00;
  logic       pm_avail = 1'b0;
  logic [7:0] rm_e     = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      pm_data = 8'h00;
      pm_avail = 1'b0;
    end else begin
      if ((serialPortState[1] && !pm_avail) || serialPortData !== pm_data) begin
        n_vec++;
        if (rx_exp.size() == 0) begin
          n_err++;
          $display("FAIL rx_unexpected: got %h, want no byte", serialPortData);
        end else begin
          rm_e = rx_exp.pop_front();
          if (serialPortData !== rm_e || serialPortState[1] !== 1'b1) begin
            n_err++;
            $display("FAIL rx_byte: got %h avail %b, want %h avail 1",
                     serialPortData, serialPortState[1], rm_e);
          end
        end
      end
      pm_data = serialPortData;
      pm_avail = serialPortState[1];
    end
  end

  logic [7:0] rb;
  logic [7:0] tb_b;
  int         t;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", {7'b0, txd}, 8'h01);
    check_status("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

`ifdef SERIAL_LOOPBACK_EN
    rx_exp.push_back(8'hC3);
    do_write(2'b10, 8'hC3);
    exp_data = 8'hC3;
    exp_avail = 1'b1;
    wait_tx_idle();
    repeat (8) @(posedge clk);
    #1;
    check_status("loop");
    do_read(2'b10);
    check_status("loop_rd");
`else
    do_write(2'b10, 8'hA5);
    check_status("a5_busy");
    do_write(2'b10, 8'h3C);
    do_write(2'b00, 8'h77);
    wait_tx_idle();
    check_status("a5_done");
    do_write(2'b00, 8'h5F);
    do_write(2'b11, 8'h60);
    repeat (12 * CPB) @(posedge clk);
    #1;
    check_status("no_frame");

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 100)) @(posedge clk);
      tb_b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) do_write(2'($urandom_range(0, 3)), tb_b);
      else do_write(2'b10, tb_b);
      check_status("tx_rand");
    end
    wait_tx_idle();

    do_write(2'b10, 8'h81);
    while (cyc < busy_until - 2) begin
      @(posedge clk); #1;
    end
    do_write(2'b10, 8'h7E);
    wait_tx_idle();
    check_status("b2b");

    send_frame(8'h5A, 1'b1);
    check_status("rx5a");
    do_read(2'b10);
    check_status("rx5a_rd");

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_status("overrun");
    send_frame(8'hE7, 1'b0);
    check_status("framing");

    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check_status("glitch");
    do_read(2'b10);
    check_status("clr");

    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      send_frame(rb, $urandom_range(0, 4) != 0);
      check_status("rx_rand");
      if ($urandom_range(0, 1) == 1) begin
        do_read(2'($urandom_range(0, 3)));
        check_status("rx_rd_any");
      end
      do_read(2'b10);
      check_status("rx_rd");
    end

    rb = 8'($urandom);
    fork
      do_write(2'b10, 8'($urandom));
      send_frame(rb, 1'b1);
    join
    wait_tx_idle();
    check_status("both");
    do_read(2'b10);
`endif

    wait_tx_idle();
    do_write(2'b10, 8'h96);
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b0;
    busy_until = 0;
    exp_avail = 1'b0;
    exp_data = 8'h00;
    #1;
    check("abort_txd", {7'b0, txd}, 8'h01);
    check_status("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_txd", {7'b0, txd}, 8'h01);

    t = 0;
    while ((tm_act || tx_exp.size() != 0 || rx_exp.size() != 0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_tx", 8'(tx_exp.size()), 8'h00);
    check("drain_rx", 8'(rx_exp.size()), 8'h00);
    check("drain_mon", {7'b0, tm_act}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
